// File: rtl/stage1_issue_ctrl.sv
// Stage1 issue control: 2-entry fetch FIFO feeding a registered decode slot,
// with load-use bubbles, external stall freeze, post-redirect squash and perf counters.
module stage1_issue_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_2000,
  parameter int          FLUSH_CYCLES = 1,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             if_valid,
  input  logic [31:0]      if_inst,
  input  logic [31:0]      if_pc,
  output logic             if_ready,
  input  logic             stall_ext,
  input  logic             flush,
  input  logic             ex_load_valid,
  input  logic [4:0]       ex_rd,
  output logic             id_valid,
  output logic [31:0]      id_inst,
  output logic [31:0]      id_pc,
  output logic [CNT_W-1:0] bubble_cnt,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam int FC_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES + 1) : 1;
  localparam logic [FC_W-1:0] FC_LOAD = FC_W'(FLUSH_CYCLES);

  typedef enum logic [1:0] {S_RUN, S_BUBBLE, S_FLUSH} state_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_t;

  state_t          state;
  logic [FC_W-1:0] fl_cnt;
  fetch_t [1:0]    fifo_q;
  logic            rd_ptr, wr_ptr;
  logic [1:0]      count;

  fetch_t head;
  logic   head_vld;
  logic   use_rs1, use_rs2;
  logic   hazard;
  logic   accept, push, pop, do_bubble;

  assign head     = fifo_q[rd_ptr];
  assign head_vld = (count != 2'd0);

  // Count is registered: a full FIFO refuses a beat even if it pops this edge.
  assign if_ready = (state == S_FLUSH) || (count < 2'd2);
  assign accept   = if_valid && if_ready;

  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    case (head.inst[6:0])
      7'b0110011, 7'b0100011, 7'b1100011: begin
        use_rs1 = 1'b1;
        use_rs2 = 1'b1;
      end
      7'b0010011, 7'b0000011, 7'b1100111: use_rs1 = 1'b1;
      default: ;
    endcase
  end

  assign hazard = (state == S_RUN) && head_vld && ex_load_valid && (ex_rd != 5'd0) &&
                  ((use_rs1 && (head.inst[19:15] == ex_rd)) ||
                   (use_rs2 && (head.inst[24:20] == ex_rd)));

  // BUBBLE skips the hazard check: the slot it just emptied is the bubble.
  always_comb begin
    push      = accept && !flush && (state != S_FLUSH);
    pop       = 1'b0;
    do_bubble = 1'b0;
    if (!flush && (state != S_FLUSH) && !stall_ext) begin
      if (hazard)        do_bubble = 1'b1;
      else if (head_vld) pop       = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      fifo_q <= '0;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else if (flush) begin
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr] <= '{inst: if_inst, pc: if_pc};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_RUN;
      fl_cnt   <= '0;
      id_valid <= 1'b0;
      id_inst  <= NOP;
      id_pc    <= RESET_PC;
    end else if (flush) begin
      id_valid <= 1'b0;
      id_inst  <= NOP;
      fl_cnt   <= FC_LOAD;
      if (FLUSH_CYCLES > 0) state <= S_FLUSH;
      else                  state <= S_RUN;
    end else if (state == S_FLUSH) begin
      // Squash window keeps counting down even under stall_ext.
      fl_cnt <= fl_cnt - 1'b1;
      if (fl_cnt <= FC_W'(1)) state <= S_RUN;
    end else if (stall_ext) begin
      state <= state;
    end else if (do_bubble) begin
      id_valid <= 1'b0;
      id_inst  <= NOP;
      state    <= S_BUBBLE;
    end else if (pop) begin
      id_valid <= 1'b1;
      id_inst  <= head.inst;
      id_pc    <= head.pc;
      state    <= S_RUN;
    end else begin
      id_valid <= 1'b0;
      id_inst  <= NOP;
      state    <= S_RUN;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_cnt <= '0;
      stall_cnt  <= '0;
    end else begin
      if (do_bubble && (bubble_cnt != '1)) bubble_cnt <= bubble_cnt + CNT_W'(1);
      if (stall_ext && (stall_cnt != '1))  stall_cnt  <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: doc/stage1_issue_ctrl.md
Name: stage1_issue_ctrl

Overview:
Sequences instruction issue through decode (stage1). Buffers fetched instructions in a 2-entry FIFO and drives the registered decode output toward stage2. Inserts a one-cycle bubble on load-use hazards, freezes on external stalls, and squashes wrong-path fetches after a redirect flush. Keeps saturating bubble and stall counters for performance monitoring.

Parameters:
RESET_PC, 32'h0000_2000, value of id_pc at reset.
FLUSH_CYCLES, 1, cycles after a flush during which accepted fetch beats are discarded (0 = clear only).
CNT_W, 16, width of the performance counters.

Ports:
clk  input  1  clock, all state on rising edge
reset_n  input  1  asynchronous active-low reset
if_valid  input  1  fetch beat valid
if_inst  input  32  fetched instruction
if_pc  input  32  PC of fetched instruction
if_ready  output  1  block accepts a fetch beat this cycle
stall_ext  input  1  downstream stall (cache miss); freeze issue
flush  input  1  redirect from stage2; squash all buffered and decode state
ex_load_valid  input  1  instruction issued last cycle is a load
ex_rd  input  5  destination register of that load
id_valid  output  1  id_inst/id_pc hold a real instruction
id_inst  output  32  registered instruction to decode/stage2
id_pc  output  32  registered PC
bubble_cnt  output  CNT_W  load-use bubbles inserted, saturating
stall_cnt  output  CNT_W  cycles with stall_ext high, saturating

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low. Reset values: id_valid=0, id_inst=32'h0000_0013 (NOP), id_pc=RESET_PC, FIFO empty, state=RUN, flush counter 0, both perf counters 0.
- if_ready=1 when state=FLUSH, otherwise when the FIFO count is less than 2. The FIFO count is registered, so a full FIFO never accepts a push, even if it pops in the same cycle. Accept = if_valid && if_ready.
- No bypass. A beat accepted at edge k appears on id_* after edge k+1 at the earliest. FIFO order is strictly preserved.
- Source-register use of the FIFO head (opcode = inst[6:0], rs1 = inst[19:15], rs2 = inst[24:20]):
  - 0110011, 0100011, 1100011: use rs1 and rs2.
  - 0010011, 0000011, 1100111: use rs1 only.
  - All other opcodes (including LUI, AUIPC, JAL): use neither.
- hazard = RUN && head valid && ex_load_valid && ex_rd != 0 && ex_rd matches a used source register.
- Edge priority, evaluated in this order:
  1. flush: FIFO cleared, id_valid<=0, id_inst<=NOP, id_pc held. If FLUSH_CYCLES>0, state<=FLUSH with counter<=FLUSH_CYCLES; otherwise state<=RUN. A flush also overrides stall_ext, and a flush during FLUSH reloads the counter.
  2. FLUSH state: accepted beats are dropped. The counter decrements every cycle, including while stall_ext is high. When the counter reaches 1, state<=RUN on that edge. No issue occurs in FLUSH; id_valid stays 0.
  3. stall_ext: id_*, FIFO head and state all hold. Pushes still occur if there is room.
  4. RUN with hazard: id_valid<=0, id_inst<=NOP, head retained, state<=BUBBLE, bubble_cnt increments.
  5. RUN or BUBBLE with head valid: id_*<={1, head}, pop, state<=RUN. The hazard check is ignored in BUBBLE, because the downstream slot is the bubble itself.
  6. RUN or BUBBLE with the FIFO empty: id_valid<=0, id_inst<=NOP, state<=RUN.
- stall_cnt increments on every edge where stall_ext=1, regardless of state or flush. Both counters saturate at all-ones.
- Push and pop on the same edge leave the count unchanged. Flush discards a push made on the same edge.
- Reset asserted mid-operation returns every register to its reset value immediately; in-flight beats are lost.

Test Plan:
1. Reset check: hold reset_n=0, then release. Required: id_valid=0, id_inst=0x00000013, id_pc=0x2000, counters=0, if_ready=1.
2. Streaming: offer back-to-back beats pc 0x2000 and 0x2004 (addi), stall_ext=0. Required: id_valid high on two consecutive cycles with PCs in order; first issue one cycle after its accept.
3. Load-use, hazard case: head is add x6,x5,x7 (0x00728333), ex_load_valid=1, ex_rd=5. Required: one bubble cycle (id_valid=0, id_inst=NOP), add issued the next cycle, bubble_cnt=1.
4. Load-use, no-hazard cases: repeat scenario 3 with ex_rd=0, and separately with a LUI at the head. Required: no bubble in either case.
5. Stall: fill the FIFO, then hold stall_ext=1 for 3 cycles. Required: id_* held, if_ready=0, stall_cnt=3; normal issue resumes after release.
6. Flush: FLUSH_CYCLES=2, FIFO holds 2 entries, stall_ext=1, pulse flush, then offer 3 beats. Required: id_valid=0, first two beats dropped, third beat issued; stall counting continues.
7. Saturation: set CNT_W=4 and apply 20 stall cycles. Required: stall_cnt=15.
